// File: rtl/fetch_pc_controller_pkg.sv
// Shared definitions for the fetch PC controller: address width, FSM state
// type and word-alignment helper.
package fetch_pc_controller_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } pc_state_e;

  // Clears the byte-offset bits so every fetch address is word aligned.
  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
    return {addr[DATA_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_controller.sv
// Fetch-stage program counter: sequential increment, prioritised ex/id
// redirects, and holding of a redirect that arrives while the pipe is stalled.
module fetch_pc_controller
  import fetch_pc_controller_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  id_redirect_i,
  input  logic [DATA_WIDTH-1:0] id_target_i,
  input  logic                  ex_redirect_i,
  input  logic [DATA_WIDTH-1:0] ex_target_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  if_id_flush_o,
  output logic                  target_misaligned_o,
  output logic                  pending_o
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  pc_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  misaligned_q, misaligned_d;

  logic                  incoming_valid;
  logic [DATA_WIDTH-1:0] incoming_target;
  logic [DATA_WIDTH-1:0] load_target;
  logic                  load_en;

  // The execute stage is older in program order, so its redirect wins.
  assign incoming_valid  = ex_redirect_i | id_redirect_i;
  assign incoming_target = ex_redirect_i ? ex_target_i : id_target_i;

  assign load_en     = !stall_i && (incoming_valid || (state_q == PENDING));
  assign load_target = incoming_valid ? incoming_target : pend_addr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_addr_d  = pend_addr_q;
    misaligned_d = 1'b0;

    if (stall_i) begin
      if (incoming_valid) begin
        pend_addr_d = incoming_target;
        state_d     = PENDING;
      end
    end else if (load_en) begin
      pc_d         = word_align(load_target);
      misaligned_d = |load_target[1:0];
      state_d      = RUN;
    end else begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pend_addr_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_o                = pc_q;
  assign pc_plus4_o          = pc_q + PC_STEP;
  // Gated by reset so the IF/ID register is never killed while held in reset.
  assign if_id_flush_o       = load_en && !rst_i;
  assign target_misaligned_o = misaligned_q;
  assign pending_o           = (state_q == PENDING);

endmodule

// File: tb/tb_fetch_pc_controller.sv
// Directed bench for fetch_pc_controller: inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_fetch_pc_controller;
  import fetch_pc_controller_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b0;
  logic                  stall_i = 1'b0;
  logic                  id_redirect_i = 1'b0;
  logic [DATA_WIDTH-1:0] id_target_i = '0;
  logic                  ex_redirect_i = 1'b0;
  logic [DATA_WIDTH-1:0] ex_target_i = '0;
  logic [DATA_WIDTH-1:0] pc_o;
  logic [DATA_WIDTH-1:0] pc_plus4_o;
  logic                  if_id_flush_o;
  logic                  target_misaligned_o;
  logic                  pending_o;

  int vectors = 0;
  int miscompares = 0;

  fetch_pc_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .stall_i             (stall_i),
    .id_redirect_i       (id_redirect_i),
    .id_target_i         (id_target_i),
    .ex_redirect_i       (ex_redirect_i),
    .ex_target_i         (ex_target_i),
    .pc_o                (pc_o),
    .pc_plus4_o          (pc_plus4_o),
    .if_id_flush_o       (if_id_flush_o),
    .target_misaligned_o (target_misaligned_o),
    .pending_o           (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    stall_i       = 1'b0;
    id_redirect_i = 1'b0;
    id_target_i   = '0;
    ex_redirect_i = 1'b0;
    ex_target_i   = '0;
  endtask

  task automatic test_reset();
    id_redirect_i = 1'b1;
    id_target_i   = 32'h0000_1234;
    #1 rst_i = 1'b1;
    #2;
    vectors++;
    if (pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc_o, 32'h0); end
    vectors++;
    if (if_id_flush_o !== 1'b0) begin miscompares++; $display("FAIL reset_flush got %b want 0", if_id_flush_o); end
    vectors++;
    if (pending_o !== 1'b0 || target_misaligned_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got pend=%b mis=%b want 0/0", pending_o, target_misaligned_o);
    end
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b0;
    $display("test_reset: pc=%h flush=%b", pc_o, if_id_flush_o);
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      #1;
      vectors++;
      if (pc_o !== exp_pc || if_id_flush_o !== 1'b0) begin
        miscompares++; $display("FAIL seq_pc%0d got pc=%h flush=%b want pc=%h flush=0", i, pc_o, if_id_flush_o, exp_pc);
      end
      vectors++;
      if (pc_plus4_o !== exp_pc + 32'd4) begin
        miscompares++; $display("FAIL seq_plus4_%0d got %h want %h", i, pc_plus4_o, exp_pc + 32'd4);
      end
      $display("test_sequential: cycle %0d pc=%h", i, pc_o);
      @(negedge clk_i);
    end
  endtask

  task automatic test_id_redirect();
    ex_redirect_i = 1'b1;
    ex_target_i   = 32'h0000_1000;
    @(negedge clk_i);
    clear_inputs();
    #1;
    vectors++;
    if (pc_o !== 32'h1000) begin miscompares++; $display("FAIL id_setup_pc got %h want %h", pc_o, 32'h1000); end
    id_redirect_i = 1'b1;
    id_target_i   = 32'h0000_0FFC;
    #1;
    vectors++;
    if (if_id_flush_o !== 1'b1) begin miscompares++; $display("FAIL id_flush got %b want 1", if_id_flush_o); end
    @(negedge clk_i);
    clear_inputs();
    #1;
    vectors++;
    if (pc_o !== 32'h0FFC || if_id_flush_o !== 1'b0) begin
      miscompares++; $display("FAIL id_target got pc=%h flush=%b want pc=%h flush=0", pc_o, if_id_flush_o, 32'h0FFC);
    end
    $display("test_id_redirect: pc=%h", pc_o);
  endtask

  task automatic test_priority();
    ex_redirect_i = 1'b1;
    ex_target_i   = 32'h0000_2000;
    id_redirect_i = 1'b1;
    id_target_i   = 32'h0000_3000;
    @(negedge clk_i);
    clear_inputs();
    #1;
    vectors++;
    if (pc_o !== 32'h2000) begin miscompares++; $display("FAIL ex_over_id got %h want %h", pc_o, 32'h2000); end
    $display("test_priority: pc=%h", pc_o);
  endtask

  task automatic test_stall_pending();
    logic [31:0] held_pc;
    held_pc = pc_o;
    stall_i       = 1'b1;
    id_redirect_i = 1'b1;
    id_target_i   = 32'h0000_4000;
    #1;
    vectors++;
    if (if_id_flush_o !== 1'b0) begin miscompares++; $display("FAIL stall_flush_in got %b want 0", if_id_flush_o); end
    @(negedge clk_i);
    id_redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (pc_o !== held_pc || pending_o !== 1'b1 || if_id_flush_o !== 1'b0) begin
        miscompares++; $display("FAIL stall_hold%0d got pc=%h pend=%b flush=%b want pc=%h pend=1 flush=0",
                                i, pc_o, pending_o, if_id_flush_o, held_pc);
      end
      @(negedge clk_i);
    end
    stall_i = 1'b0;
    #1;
    vectors++;
    if (if_id_flush_o !== 1'b1) begin miscompares++; $display("FAIL pend_release_flush got %b want 1", if_id_flush_o); end
    @(negedge clk_i);
    #1;
    vectors++;
    if (pc_o !== 32'h4000 || pending_o !== 1'b0) begin
      miscompares++; $display("FAIL pend_apply got pc=%h pend=%b want pc=%h pend=0", pc_o, pending_o, 32'h4000);
    end
    $display("test_stall_pending: pc=%h", pc_o);
  endtask

  task automatic test_back_to_back();
    // Newer redirect during stall overwrites the held one.
    stall_i       = 1'b1;
    id_redirect_i = 1'b1;
    id_target_i   = 32'h0000_7000;
    @(negedge clk_i);
    id_redirect_i = 1'b0;
    ex_redirect_i = 1'b1;
    ex_target_i   = 32'h0000_7100;
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
    #1;
    vectors++;
    if (pc_o !== 32'h7100) begin miscompares++; $display("FAIL pend_overwrite got %h want %h", pc_o, 32'h7100); end
    // A fresh redirect on the release cycle beats the held one.
    stall_i       = 1'b1;
    id_redirect_i = 1'b1;
    id_target_i   = 32'h0000_8000;
    @(negedge clk_i);
    stall_i     = 1'b0;
    id_target_i = 32'h0000_8100;
    @(negedge clk_i);
    clear_inputs();
    #1;
    vectors++;
    if (pc_o !== 32'h8100 || pending_o !== 1'b0) begin
      miscompares++; $display("FAIL pend_discard got pc=%h pend=%b want pc=%h pend=0", pc_o, pending_o, 32'h8100);
    end
    @(negedge clk_i);
    #1;
    vectors++;
    if (pc_o !== 32'h8104) begin miscompares++; $display("FAIL pend_not_reapplied got %h want %h", pc_o, 32'h8104); end
    $display("test_back_to_back: pc=%h", pc_o);
  endtask

  task automatic test_misaligned_wrap();
    id_redirect_i = 1'b1;
    id_target_i   = 32'h0000_5002;
    @(negedge clk_i);
    clear_inputs();
    #1;
    vectors++;
    if (pc_o !== 32'h5000 || target_misaligned_o !== 1'b1) begin
      miscompares++; $display("FAIL misalign_load got pc=%h mis=%b want pc=%h mis=1", pc_o, target_misaligned_o, 32'h5000);
    end
    @(negedge clk_i);
    #1;
    vectors++;
    if (pc_o !== 32'h5004 || target_misaligned_o !== 1'b0) begin
      miscompares++; $display("FAIL misalign_pulse got pc=%h mis=%b want pc=%h mis=0", pc_o, target_misaligned_o, 32'h5004);
    end
    ex_redirect_i = 1'b1;
    ex_target_i   = 32'hFFFF_FFFC;
    @(negedge clk_i);
    clear_inputs();
    #1;
    vectors++;
    if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0 || target_misaligned_o !== 1'b0) begin
      miscompares++; $display("FAIL wrap_top got pc=%h plus4=%h mis=%b want pc=fffffffc plus4=0 mis=0",
                              pc_o, pc_plus4_o, target_misaligned_o);
    end
    @(negedge clk_i);
    #1;
    vectors++;
    if (pc_o !== 32'h0) begin miscompares++; $display("FAIL wrap_zero got %h want %h", pc_o, 32'h0); end
    $display("test_misaligned_wrap: pc=%h", pc_o);
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    stall_i       = 1'b1;
    id_redirect_i = 1'b1;
    id_target_i   = 32'h0000_6000;
    @(negedge clk_i);
    id_redirect_i = 1'b0;
    #1;
    vectors++;
    if (pending_o !== 1'b1) begin miscompares++; $display("FAIL async_setup got pend=%b want 1", pending_o); end
    #1 rst_i = 1'b1;
    #1;
    vectors++;
    if (pc_o !== 32'h0 || pending_o !== 1'b0 || if_id_flush_o !== 1'b0) begin
      miscompares++; $display("FAIL async_reset got pc=%h pend=%b flush=%b want pc=0 pend=0 flush=0",
                              pc_o, pending_o, if_id_flush_o);
    end
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b0;
    #1;
    vectors++;
    if (pc_o !== 32'h0 || if_id_flush_o !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_pc got pc=%h flush=%b want pc=0 flush=0", pc_o, if_id_flush_o);
    end
    @(negedge clk_i);
    #1;
    vectors++;
    if (pc_o !== 32'h4) begin miscompares++; $display("FAIL post_reset_seq got %h want %h", pc_o, 32'h4); end
    $display("test_async_reset: pc=%h", pc_o);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_id_redirect();
    test_priority();
    test_stall_pending();
    test_back_to_back();
    test_misaligned_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc_controller.md
FETCH_PC_CONTROLLER -- requirements
Module: fetch_pc_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 clk_i  input  1  single clock, rising-edge active.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 stall_i  input  1  hazard-unit stall; PC holds while high.
REQ-005 id_redirect_i  input  1  decode-stage taken branch/JAL, one-cycle qualifier.
REQ-006 id_target_i  input  DATA_WIDTH  decode branch target (PC + immediate).
REQ-007 ex_redirect_i  input  1  execute-stage JALR/mispredict redirect, one-cycle qualifier.
REQ-008 ex_target_i  input  DATA_WIDTH  execute redirect target.
REQ-009 pc_o  output  DATA_WIDTH  current fetch address (registered).
REQ-010 pc_plus4_o  output  DATA_WIDTH  pc_o + 4, combinational, modulo 2^32.
REQ-011 if_id_flush_o  output  1  kill instruction in IF/ID this cycle.
REQ-012 target_misaligned_o  output  1  registered one-cycle pulse: loaded target had nonzero bits [1:0].
REQ-013 pending_o  output  1  high while a redirect is held during stall.

Function
REQ-014 Two-state FSM: RUN, PENDING; state register plus pend_addr_q (DATA_WIDTH).
REQ-015 Redirect source priority: ex_redirect_i > id_redirect_i > pending redirect > sequential pc_o+4.
REQ-016 RUN, stall_i=0, no redirect: pc_o <= pc_o+4 next edge; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-017 stall_i=0 with any redirect (incoming or pending): pc_o <= selected target with bits [1:0] forced to 0, next edge; state -> RUN.
REQ-018 stall_i=1: pc_o holds; incoming redirect (highest priority of ex/id) captured into pend_addr_q, state -> PENDING.
REQ-019 PENDING, stall_i=1, new redirect: overwrites pend_addr_q (newer redirect wins); no redirect: pend_addr_q holds.
REQ-020 PENDING, stall_i=0: pending target applied per REQ-017 unless an ex/id redirect arrives same cycle, which takes priority and pending is discarded.
REQ-021 if_id_flush_o = combinational, high exactly in cycles where REQ-017 loads a target (stall_i=0 and (ex_redirect_i or id_redirect_i or state==PENDING)); low otherwise, including stall cycles.
REQ-022 target_misaligned_o high for one cycle after an edge loading a target whose original bits [1:0] != 2'b00; else low.
REQ-023 pending_o = (state == PENDING).
REQ-024 Latency: redirect accepted at edge N appears on pc_o after edge N; zero bubble beyond the one flushed IF/ID slot.
REQ-025 All arithmetic unsigned DATA_WIDTH, carry discarded.

Reset
REQ-026 rst_i asserted: pc_o = RESET_PC, state = RUN, pend_addr_q = 0, target_misaligned_o = 0, immediately (asynchronous).
REQ-027 Reset mid-PENDING discards the held redirect; first post-reset fetch is RESET_PC.
REQ-028 During reset if_id_flush_o = 0 regardless of inputs.

Structure
REQ-029 DATA_WIDTH and the FSM state enum (pc_state_e: RUN, PENDING) defined in the shared defines package.
REQ-030 Single module; no sub-modules; target addition stays in decode, this block only selects and registers.

Verification
REQ-031 Reset release, no stall, 4 cycles -> pc_o = 0x0, 0x4, 0x8, 0xC; flush low throughout.
REQ-032 pc_o=0x1000, id_redirect_i=1, id_target_i=0x0FFC -> if_id_flush_o=1 that cycle, pc_o=0x0FFC next cycle.
REQ-033 Same cycle ex_redirect_i target 0x2000 and id_redirect_i target 0x3000 -> pc_o=0x2000.
REQ-034 stall_i=1 with id_redirect_i target 0x4000, stall held 3 cycles -> pc_o holds, pending_o=1, flush=0; stall drops -> flush=1, pc_o=0x4000 next, pending_o=0.
REQ-035 Redirect to 0x5002 -> pc_o=0x5000, target_misaligned_o pulses one cycle; pc_o=0xFFFF_FFFC unstalled -> next pc_o=0x0.
REQ-036 rst_i asserted asynchronously while PENDING (target 0x6000) -> pc_o=RESET_PC immediately, pending_o=0, 0x6000 never fetched.
